// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern loader/sequencer pair: FSM states,
// logic-level constants and default geometry.
package pattern_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      LOADING = 2'd1,
      READY   = 2'd2
   } state_t;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

   localparam int WORD_SIZE_DEF    = 8;
   localparam int ADDRESS_SIZE_DEF = 4;
   localparam int MEMORY_QTY_DEF   = 16;

endpackage

// File: rtl/pattern_ram.sv
// Flop-array pattern store: one synchronous write port and a zero-latency
// combinational read port; contents are not reset.
module pattern_ram #(
   parameter int WORD_SIZE    = 8,
   parameter int ADDRESS_SIZE = 4,
   parameter int MEMORY_QTY   = 16
) (
   input  logic                    clock,
   input  logic                    we,
   input  logic [ADDRESS_SIZE-1:0] waddr,
   input  logic [WORD_SIZE-1:0]    wdata,
   input  logic [ADDRESS_SIZE-1:0] raddr,
   output logic [WORD_SIZE-1:0]    rdata
);

   logic [WORD_SIZE-1:0] mem [MEMORY_QTY];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Addresses beyond the physical depth read as zero when depth < 2**ADDRESS_SIZE.
   assign rdata = ({1'b0, raddr} < (ADDRESS_SIZE+1)'(MEMORY_QTY)) ? mem[raddr] : '0;

endmodule

// File: rtl/pattern_loader.sv
// Loads a pattern from a ready/valid word stream into pattern_ram and serves
// zero-latency reads once complete; w_ready drops while a pattern is held.
module pattern_loader
   import pattern_pkg::*;
#(
   parameter int WORD_SIZE    = WORD_SIZE_DEF,
   parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF,
   parameter int MEMORY_QTY   = MEMORY_QTY_DEF
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    w_valid,
   input  logic [WORD_SIZE-1:0]    w_data,
   input  logic                    w_last,
   output logic                    w_ready,
   input  logic                    clear,
   input  logic                    r_en,
   input  logic [ADDRESS_SIZE-1:0] r_addr,
   output logic [WORD_SIZE-1:0]    r_data,
   output logic                    r_ready,
   output logic [ADDRESS_SIZE:0]   length,
   output logic                    overflow
);

   state_t                  state, state_nxt;
   logic [ADDRESS_SIZE-1:0] wptr, wptr_nxt;
   logic [ADDRESS_SIZE:0]   length_nxt;
   logic                    overflow_nxt;
   logic                    accept;
   logic                    we;
   logic [ADDRESS_SIZE:0]   wcount;
   logic [WORD_SIZE-1:0]    ram_rdata;
   logic                    read_hit;

   assign w_ready = (state != READY);
   assign r_ready = (state == READY);
   assign accept  = w_valid & w_ready;
   assign wcount  = {1'b0, wptr} + 1'b1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= EMPTY;
         wptr     <= '0;
         length   <= '0;
         overflow <= OFF;
      end else begin
         state    <= state_nxt;
         wptr     <= wptr_nxt;
         length   <= length_nxt;
         overflow <= overflow_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wptr_nxt     = wptr;
      length_nxt   = length;
      overflow_nxt = overflow;
      we           = OFF;
      // clear wins over a same-cycle accept; that word is never written.
      if (clear) begin
         state_nxt    = EMPTY;
         wptr_nxt     = '0;
         length_nxt   = '0;
         overflow_nxt = OFF;
      end else if (accept) begin
         we       = ON;
         wptr_nxt = wcount[ADDRESS_SIZE-1:0];
         if (w_last) begin
            length_nxt = wcount;
            state_nxt  = READY;
         end else if (wcount == (ADDRESS_SIZE+1)'(MEMORY_QTY)) begin
            length_nxt   = (ADDRESS_SIZE+1)'(MEMORY_QTY);
            overflow_nxt = ON;
            state_nxt    = READY;
         end else begin
            state_nxt = LOADING;
         end
      end
   end

   pattern_ram #(
      .WORD_SIZE    (WORD_SIZE),
      .ADDRESS_SIZE (ADDRESS_SIZE),
      .MEMORY_QTY   (MEMORY_QTY)
   ) u_ram (
      .clock (clock),
      .we    (we),
      .waddr (wptr),
      .wdata (w_data),
      .raddr (r_addr),
      .rdata (ram_rdata)
   );

   assign read_hit = r_ready & r_en & ({1'b0, r_addr} < length);
   assign r_data   = read_hit ? ram_rdata : '0;

endmodule
